noisy_sig_gen: RTL and testbench
================================

// Module: noisy_sig_gen
// PURPOSE
//  Stimulus source for the lowpass FIR datapath: 16-bit signed samples, one per clk (100 MHz).
//  Each sample is a wanted tone (DDS A) + an out-of-band interferer tone (DDS B) + LFSR white noise.
//  Sums saturate to 16 bits. Output drives the FIR noisy_signal input on-chip, for bring-up and BIST.
// PARAMETERS
//  PHASE_W    32       phase accumulator width (bits)
//  LUT_AW     8        quarter-wave sine LUT address width (2^LUT_AW entries)
//  LFSR_SEED  16'hACE1 LFSR reset value; 0 is illegal and is replaced by 16'hACE1
// PORTS
//  clk           in   1        system clock
//  rst_n         in   1        synchronous reset, active low
//  enable        in   1        advance accumulators/LFSR and emit a sample this cycle
//  fcw_a         in   PHASE_W  tone A frequency control word (f = fcw*Fs/2^PHASE_W)
//  fcw_b         in   PHASE_W  tone B (interferer) frequency control word
//  tone_b_en     in   1        include tone B in the sum
//  noise_en      in   1        include noise in the sum
//  noise_shift   in   4        noise attenuation: noise >>> noise_shift
//  sample_out    out  16       signed output sample
//  sample_valid  out  1        sample_out holds a new sample
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): phase_a=phase_b=0, lfsr=LFSR_SEED (or ACE1 if seed is 0),
//   valid pipe cleared, sample_out=0, sample_valid=0. Reset mid-stream discards in-flight samples.
//  Phase: on enable, sample uses current phase, then phase += fcw (mod 2^PHASE_W, wraps silently).
//   fcw changes apply to the next accumulation. enable=0: phases and lfsr hold.
//  Sine: q = phase[MSB:MSB-1], addr = next LUT_AW bits; addr is inverted (~addr) when q is 1 or 3.
//   Value is negated when q is 2 or 3.
//   LUT[k] = round(32767*sin(pi/2*k/2^LUT_AW)), unsigned 15-bit magnitude, synthesised ROM.
//  Noise: Galois right-shift LFSR, mask 16'hB400 (x^16+x^14+x^13+x^11+1).
//   The sample uses the current state; on enable: state = (state>>1) ^ (state[0] ? 16'hB400 : 0).
//   noise = $signed(state) >>> noise_shift.
//  Sum (18-bit signed): (sinA>>>1) + (tone_b_en ? sinB>>>2 : 0) + (noise_en ? noise : 0).
//   Saturate to [-32768, 32767]. Control inputs are sampled in the same cycle as phase/lfsr.
//  Pipeline: 3 stages, each advancing every clk.
//   S1: quadrant and address register. S2: LUT read and sign fix. S3: sum and saturate.
//   sample_valid = enable delayed by 3 cycles. sample_out updates only when the S3 valid bit is 1;
//   otherwise it holds its last value.
//  An enable gap produces a matching gap in sample_valid, 3 cycles later. No sample is lost or duplicated.
//  Continuous enable produces valid on every cycle: throughput is 1 sample/clk.
// TESTING
//  1 Reset: hold rst_n=0 for 5 clk with enable=1 -> sample_out=0, sample_valid=0 throughout.
//  2 fcw_a=2^30, tone B and noise off, enable=1 from reset release ->
//    from cycle 3, samples 0, 16383, 0, -16383 repeating.
//  3 Same as test 2 plus tone_b_en=1, fcw_b=2^30 -> 0, 24574, 0, -24575 (sat not hit).
//  4 Saturation: LFSR_SEED=16'hFFFE, fcw_a=2^30, noise_en=1, noise_shift=0 ->
//    sample0 = -2, sample1 = 32767 (clamped from 49150).
//  5 Drop enable for 2 cycles mid-stream -> sample_valid low for exactly 2 cycles, 3 cycles later.
//    Next sample continues the phase sequence; no repeat, no skip.
//  6 Random fcw/shift/enable, 10k cycles -> bit-exact match vs a behavioural model, including
//    phase wrap and both saturation rails.

Source files
------------

// File: rtl/noisy_sig_gen.sv
// noisy_sig_gen
//   Test-signal source for the lowpass FIR datapath. Each enabled cycle emits one
//   16-bit signed sample that is the sum of three parts:
//     - wanted tone A at half scale,
//     - optional interferer tone B at quarter scale,
//     - optional LFSR white noise, arithmetically attenuated by noise_shift.
//   The sum saturates to 16 bits. A 3-stage pipeline gives one sample per clk.
// Ports
//   clk           system clock
//   rst_n         synchronous reset, active low
//   enable        advance phases/LFSR and launch a sample this cycle
//   fcw_a, fcw_b  frequency control words for tone A and tone B
//   tone_b_en     add tone B to the sum
//   noise_en      add noise to the sum
//   noise_shift   noise attenuation (arithmetic right shift)
//   sample_out    signed output sample; holds between valid samples
//   sample_valid  sample_out carries a new sample (enable delayed 3 clk)
module noisy_sig_gen #(
  parameter int          PHASE_W   = 32,
  parameter int          LUT_AW    = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [PHASE_W-1:0] fcw_a,
  input  logic [PHASE_W-1:0] fcw_b,
  input  logic               tone_b_en,
  input  logic               noise_en,
  input  logic [3:0]         noise_shift,
  output logic [15:0]        sample_out,
  output logic               sample_valid
);

  // An all-zero LFSR would lock up, so a zero seed falls back to ACE1.
  localparam logic [15:0] SEED      = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;
  localparam logic [15:0] LFSR_MASK = 16'hB400;
  localparam int          LUT_DEPTH = 1 << LUT_AW;

  // Quarter-wave magnitude: round(32767*sin(pi/2*k/LUT_DEPTH)), evaluated with a
  // Taylor series so the table is fixed at elaboration and maps to a ROM.
  function automatic logic [14:0] sine_entry(input int k);
    real x;
    real term;
    real acc;
    x    = 3.14159265358979323846 / 2.0 * real'(k) / real'(LUT_DEPTH);
    term = x;
    acc  = x;
    for (int n = 1; n <= 12; n++) begin
      term = -term * x * x / real'((2 * n) * (2 * n + 1));
      acc  = acc + term;
    end
    return 15'($rtoi(32767.0 * acc + 0.5));
  endfunction

  logic [14:0] sine_rom [LUT_DEPTH];

  generate
    for (genvar gi = 0; gi < LUT_DEPTH; gi++) begin : g_rom
      assign sine_rom[gi] = sine_entry(gi);
    end
  endgenerate

  // Accumulator / LFSR state
  logic [PHASE_W-1:0] phase_a_q, phase_a_d;
  logic [PHASE_W-1:0] phase_b_q, phase_b_d;
  logic [15:0]        lfsr_q, lfsr_d;

  // S1: folded LUT address, sign flag, noise and control snapshot
  logic               s1_valid_q, s1_valid_d;
  logic [LUT_AW-1:0]  s1_addr_a_q, s1_addr_a_d;
  logic [LUT_AW-1:0]  s1_addr_b_q, s1_addr_b_d;
  logic               s1_neg_a_q, s1_neg_a_d;
  logic               s1_neg_b_q, s1_neg_b_d;
  logic signed [15:0] s1_noise_q, s1_noise_d;
  logic               s1_tone_b_en_q, s1_tone_b_en_d;
  logic               s1_noise_en_q, s1_noise_en_d;

  // S2: signed sine values
  logic               s2_valid_q, s2_valid_d;
  logic signed [15:0] s2_sin_a_q, s2_sin_a_d;
  logic signed [15:0] s2_sin_b_q, s2_sin_b_d;
  logic signed [15:0] s2_noise_q, s2_noise_d;
  logic               s2_tone_b_en_q, s2_tone_b_en_d;
  logic               s2_noise_en_q, s2_noise_en_d;

  // S3: saturated output
  logic [15:0]        sample_out_q, sample_out_d;
  logic               sample_valid_q, sample_valid_d;

  logic signed [15:0] term_a, term_b, term_n;
  logic signed [17:0] sum;

  always_comb begin
    phase_a_d = phase_a_q;
    phase_b_d = phase_b_q;
    lfsr_d    = lfsr_q;
    if (enable) begin
      phase_a_d = phase_a_q + fcw_a;
      phase_b_d = phase_b_q + fcw_b;
      lfsr_d    = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);
    end

    // Odd quadrants walk the quarter wave backwards; upper half is negative.
    s1_valid_d     = enable;
    s1_addr_a_d    = phase_a_q[PHASE_W-3 -: LUT_AW] ^ {LUT_AW{phase_a_q[PHASE_W-2]}};
    s1_addr_b_d    = phase_b_q[PHASE_W-3 -: LUT_AW] ^ {LUT_AW{phase_b_q[PHASE_W-2]}};
    s1_neg_a_d     = phase_a_q[PHASE_W-1];
    s1_neg_b_d     = phase_b_q[PHASE_W-1];
    s1_noise_d     = $signed(lfsr_q) >>> noise_shift;
    s1_tone_b_en_d = tone_b_en;
    s1_noise_en_d  = noise_en;

    s2_valid_d = s1_valid_q;
    s2_sin_a_d = {1'b0, sine_rom[s1_addr_a_q]};
    if (s1_neg_a_q) s2_sin_a_d = -s2_sin_a_d;
    s2_sin_b_d = {1'b0, sine_rom[s1_addr_b_q]};
    if (s1_neg_b_q) s2_sin_b_d = -s2_sin_b_d;
    s2_noise_d     = s1_noise_q;
    s2_tone_b_en_d = s1_tone_b_en_q;
    s2_noise_en_d  = s1_noise_en_q;

    term_a = s2_sin_a_q >>> 1;
    term_b = s2_tone_b_en_q ? (s2_sin_b_q >>> 2) : 16'sd0;
    term_n = s2_noise_en_q ? s2_noise_q : 16'sd0;
    sum    = {{2{term_a[15]}}, term_a} + {{2{term_b[15]}}, term_b} + {{2{term_n[15]}}, term_n};

    sample_valid_d = s2_valid_q;
    sample_out_d   = sample_out_q;
    if (s2_valid_q) begin
      if (sum > 18'sd32767)       sample_out_d = 16'h7FFF;
      else if (sum < -18'sd32768) sample_out_d = 16'h8000;
      else                        sample_out_d = sum[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_a_q      <= '0;
      phase_b_q      <= '0;
      lfsr_q         <= SEED;
      s1_valid_q     <= 1'b0;
      s1_addr_a_q    <= '0;
      s1_addr_b_q    <= '0;
      s1_neg_a_q     <= 1'b0;
      s1_neg_b_q     <= 1'b0;
      s1_noise_q     <= '0;
      s1_tone_b_en_q <= 1'b0;
      s1_noise_en_q  <= 1'b0;
      s2_valid_q     <= 1'b0;
      s2_sin_a_q     <= '0;
      s2_sin_b_q     <= '0;
      s2_noise_q     <= '0;
      s2_tone_b_en_q <= 1'b0;
      s2_noise_en_q  <= 1'b0;
      sample_out_q   <= '0;
      sample_valid_q <= 1'b0;
    end else begin
      phase_a_q      <= phase_a_d;
      phase_b_q      <= phase_b_d;
      lfsr_q         <= lfsr_d;
      s1_valid_q     <= s1_valid_d;
      s1_addr_a_q    <= s1_addr_a_d;
      s1_addr_b_q    <= s1_addr_b_d;
      s1_neg_a_q     <= s1_neg_a_d;
      s1_neg_b_q     <= s1_neg_b_d;
      s1_noise_q     <= s1_noise_d;
      s1_tone_b_en_q <= s1_tone_b_en_d;
      s1_noise_en_q  <= s1_noise_en_d;
      s2_valid_q     <= s2_valid_d;
      s2_sin_a_q     <= s2_sin_a_d;
      s2_sin_b_q     <= s2_sin_b_d;
      s2_noise_q     <= s2_noise_d;
      s2_tone_b_en_q <= s2_tone_b_en_d;
      s2_noise_en_q  <= s2_noise_en_d;
      sample_out_q   <= sample_out_d;
      sample_valid_q <= sample_valid_d;
    end
  end

  assign sample_out   = sample_out_q;
  assign sample_valid = sample_valid_q;

endmodule

// File: tb/tb_noisy_sig_gen.sv
// Testbench for noisy_sig_gen. Two instances share all inputs: u_dut0 uses the
// default LFSR seed, u_dut1 uses seed FFFE to reach the positive rail early.
// A behavioural model pushes the expected sample into a per-instance queue on
// every enabled edge; the entry is popped when the model's valid delay line
// says the DUT should present it.
module tb_noisy_sig_gen;
  localparam real PI = 3.14159265358979323846;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [31:0] fcw_a, fcw_b;
  logic        tone_b_en, noise_en;
  logic [3:0]  noise_shift;
  logic [15:0] sample_out0, sample_out1;
  logic        sample_valid0, sample_valid1;

  always #5 clk = ~clk;

  noisy_sig_gen u_dut0 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fcw_a(fcw_a), .fcw_b(fcw_b),
    .tone_b_en(tone_b_en), .noise_en(noise_en), .noise_shift(noise_shift),
    .sample_out(sample_out0), .sample_valid(sample_valid0)
  );

  noisy_sig_gen #(.LFSR_SEED(16'hFFFE)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fcw_a(fcw_a), .fcw_b(fcw_b),
    .tone_b_en(tone_b_en), .noise_en(noise_en), .noise_shift(noise_shift),
    .sample_out(sample_out1), .sample_valid(sample_valid1)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] m_phase_a [2];
  logic [31:0] m_phase_b [2];
  logic [15:0] m_lfsr    [2];
  logic [2:0]  m_vpipe   [2];
  int          m_last    [2];
  int          exp_q     [2][$];
  int          obs       [2][$];
  int          gap_cnt;
  int          sat_hi, sat_lo;
  bit          verbose;
  int          pat2 [4] = '{0, 16383, 0, -16383};
  int          pat3 [4] = '{0, 24574, 0, -24575};

  task automatic check_val(input string tag, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  function automatic int model_sine(input logic [31:0] ph);
    logic [1:0] q;
    int a, mag;
    q = ph[31:30];
    a = int'(ph[29:22]);
    if (q[0]) a = 255 - a;
    mag = $rtoi(32767.0 * $sin(PI / 2.0 * real'(a) / 256.0) + 0.5);
    return q[1] ? -mag : mag;
  endfunction

  task automatic model_edge(input int idx);
    int sa, sb, n, sum;
    if (!rst_n) begin
      m_phase_a[idx] = '0;
      m_phase_b[idx] = '0;
      m_lfsr[idx]    = (idx == 1) ? 16'hFFFE : 16'hACE1;
      m_vpipe[idx]   = '0;
      m_last[idx]    = 0;
      exp_q[idx].delete();
    end else begin
      m_vpipe[idx] = {m_vpipe[idx][1:0], enable};
      if (enable) begin
        sa  = model_sine(m_phase_a[idx]);
        sb  = model_sine(m_phase_b[idx]);
        n   = int'($signed(m_lfsr[idx])) >>> noise_shift;
        sum = (sa >>> 1) + (tone_b_en ? (sb >>> 2) : 0) + (noise_en ? n : 0);
        if (sum > 32767) begin
          sum = 32767;
          sat_hi++;
        end else if (sum < -32768) begin
          sum = -32768;
          sat_lo++;
        end
        exp_q[idx].push_back(sum);
        m_phase_a[idx] = m_phase_a[idx] + fcw_a;
        m_phase_b[idx] = m_phase_b[idx] + fcw_b;
        m_lfsr[idx]    = (m_lfsr[idx] >> 1) ^ (m_lfsr[idx][0] ? 16'hB400 : 16'h0000);
      end
    end
  endtask

  task automatic check_outputs(input int idx);
    logic [15:0] so;
    logic        sv;
    int          e;
    so = (idx == 1) ? sample_out1 : sample_out0;
    sv = (idx == 1) ? sample_valid1 : sample_valid0;
    check_val($sformatf("valid%0d", idx), int'(sv), int'(m_vpipe[idx][2]));
    if (m_vpipe[idx][2]) begin
      e = exp_q[idx].pop_front();
      check_val($sformatf("sample%0d", idx), int'($signed(so)), e);
      m_last[idx] = e;
      obs[idx].push_back(int'($signed(so)));
      if (verbose) $display("inst%0d sample got %0d exp %0d", idx, int'($signed(so)), e);
    end else begin
      check_val($sformatf("hold%0d", idx), int'($signed(so)), m_last[idx]);
      if (idx == 0 && obs[0].size() > 0) gap_cnt++;
    end
  endtask

  task automatic tick();
    model_edge(0);
    model_edge(1);
    @(posedge clk);
    #1;
    check_outputs(0);
    check_outputs(1);
  endtask

  task automatic begin_test();
    obs[0].delete();
    obs[1].delete();
    gap_cnt = 0;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; fcw_a = 32'h4000_0000; fcw_b = '0;
    tone_b_en = 1'b0; noise_en = 1'b0; noise_shift = '0; verbose = 1'b1;
    sat_hi = 0; sat_lo = 0;
    for (int i = 0; i < 2; i++) begin
      m_vpipe[i] = '0;
      m_last[i]  = 0;
    end

    // Reset held with enable high: outputs stay zero / invalid
    repeat (5) tick();

    // Tone A only
    begin_test();
    rst_n = 1'b1;
    repeat (10) tick();
    check_val("t2_count", obs[0].size(), 8);
    for (int i = 0; i < obs[0].size(); i++) check_val("t2_pattern", obs[0][i], pat2[i % 4]);

    // Tone A + tone B
    rst_n = 1'b0; tone_b_en = 1'b1; fcw_b = 32'h4000_0000;
    repeat (2) tick();
    begin_test();
    rst_n = 1'b1;
    repeat (10) tick();
    check_val("t3_count", obs[0].size(), 8);
    for (int i = 0; i < obs[0].size(); i++) check_val("t3_pattern", obs[0][i], pat3[i % 4]);

    // Noise at full scale, seed FFFE on u_dut1 hits the positive rail
    rst_n = 1'b0; tone_b_en = 1'b0; noise_en = 1'b1; noise_shift = 4'd0;
    repeat (2) tick();
    begin_test();
    rst_n = 1'b1;
    repeat (6) tick();
    check_val("t4_count", obs[1].size(), 4);
    if (obs[1].size() >= 2) begin
      check_val("t4_sample0", obs[1][0], -2);
      check_val("t4_sample1_sat", obs[1][1], 32767);
    end

    // Two-cycle enable gap mid-stream
    rst_n = 1'b0; noise_en = 1'b0;
    repeat (2) tick();
    begin_test();
    rst_n = 1'b1;
    repeat (5) tick();
    enable = 1'b0;
    repeat (2) tick();
    enable = 1'b1;
    repeat (10) tick();
    check_val("t5_count", obs[0].size(), 13);
    check_val("t5_gap", gap_cnt, 2);
    for (int i = 0; i < obs[0].size(); i++) check_val("t5_pattern", obs[0][i], pat2[i % 4]);

    // Random traffic against the model
    verbose = 1'b0;
    sat_hi = 0; sat_lo = 0;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      rst_n  = ($urandom_range(0, 1999) != 0);
      enable = ($urandom_range(0, 99) < 85);
      if ($urandom_range(0, 49) == 0)
        fcw_a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 65535)) : $urandom;
      if ($urandom_range(0, 49) == 0)
        fcw_b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 65535)) : $urandom;
      if ($urandom_range(0, 15) == 0) tone_b_en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) noise_en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0)
        noise_shift = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      tick();
    end
    check_val("rand_sat_hi_seen", int'(sat_hi > 0), 1);
    check_val("rand_sat_lo_seen", int'(sat_lo > 0), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
